// File: rtl/addsub_chain_pipe.sv
// Two-stage, multi-lane add/subtract chain: stage 1 forms X = A +/- U, stage 2 forms Y = X -/+ V.
// Valid/ready handshake on both sides; every lane wraps modulo 2^N independently.
module addsub_chain_pipe #(
    parameter int N     = 4,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [LANES*N-1:0]   in_a,
    input  logic [LANES*N-1:0]   in_u,
    input  logic [LANES*N-1:0]   in_v,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   out_x,
    output logic [LANES*N-1:0]   out_y,
    output logic                 out_mode
);
    localparam int W = LANES * N;

    logic         s1_valid_reg;
    logic         s1_mode_reg;
    logic [W-1:0] s1_x_reg;
    logic [W-1:0] s1_v_reg;
    logic         s2_valid_reg;
    logic         s2_mode_reg;
    logic [W-1:0] s2_x_reg;
    logic [W-1:0] s2_y_reg;

    logic [W-1:0] s1_x_next;
    logic [W-1:0] s2_y_next;
    logic         s2_adv;
    logic         s1_adv;
    logic         s1_load;
    logic         s2_load;

    // A stage may take a new beat when it is empty or its contents leave this cycle.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid && s1_adv;
    assign s2_load  = s1_valid_reg && s2_adv;

    // Per-lane slices keep carries and borrows from crossing lane boundaries.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign s1_x_next[gi*N +: N] = in_mode
                ? (in_a[gi*N +: N] - in_u[gi*N +: N])
                : (in_a[gi*N +: N] + in_u[gi*N +: N]);
            assign s2_y_next[gi*N +: N] = s1_mode_reg
                ? (s1_x_reg[gi*N +: N] + s1_v_reg[gi*N +: N])
                : (s1_x_reg[gi*N +: N] - s1_v_reg[gi*N +: N]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_x_reg     <= '0;
            s1_v_reg     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= 1'b1;
                s1_mode_reg  <= in_mode;
                s1_x_reg     <= s1_x_next;
                s1_v_reg     <= in_v;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mode_reg  <= 1'b0;
            s2_x_reg     <= '0;
            s2_y_reg     <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s2_load) begin
                s2_mode_reg <= s1_mode_reg;
                s2_x_reg    <= s1_x_reg;
                s2_y_reg    <= s2_y_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_x     = s2_x_reg;
    assign out_y     = s2_y_reg;
    assign out_mode  = s2_mode_reg;

endmodule
